// File: rtl/ponpoko_input_pkg.sv
// Shared constants for the ponpoko input conditioning stage.
// Holds PS/2 scancodes, held-key vector bit positions, joystick bit indices,
// the sequencer state type and a scancode-to-held-bit decode helper.
package ponpoko_input_pkg;

    // Direction keys match on the low byte only, so E0-prefixed codes hit too.
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;
    localparam logic [8:0] KEY_SPACE = 9'h029;
    localparam logic [8:0] KEY_CTRL  = 9'h014;
    localparam logic [8:0] KEY_F1    = 9'h005;
    localparam logic [8:0] KEY_F2    = 9'h006;
    localparam logic [8:0] KEY_F3    = 9'h004;

    // Held-key vector layout
    localparam int unsigned HELD_W   = 9;
    localparam int unsigned H_UP     = 0;
    localparam int unsigned H_DOWN   = 1;
    localparam int unsigned H_LEFT   = 2;
    localparam int unsigned H_RIGHT  = 3;
    localparam int unsigned H_SPACE  = 4;
    localparam int unsigned H_CTRL   = 5;
    localparam int unsigned H_START1 = 6;
    localparam int unsigned H_START2 = 7;
    localparam int unsigned H_COIN   = 8;

    // Joystick word bit indices
    localparam int unsigned JOY_RIGHT  = 0;
    localparam int unsigned JOY_LEFT   = 1;
    localparam int unsigned JOY_DOWN   = 2;
    localparam int unsigned JOY_UP     = 3;
    localparam int unsigned JOY_FIRE   = 4;
    localparam int unsigned JOY_START1 = 5;
    localparam int unsigned JOY_START2 = 6;
    localparam int unsigned JOY_COIN   = 7;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_COIN,
        SEQ_GAP,
        SEQ_START,
        SEQ_HOLD
    } seq_state_t;

    // One-hot of the held bit a scancode controls; zero for unmapped codes.
    function automatic logic [HELD_W-1:0] key_hit(input logic [8:0] code);
        logic [HELD_W-1:0] hit;
        hit           = '0;
        hit[H_UP]     = (code[7:0] == KEY_UP);
        hit[H_DOWN]   = (code[7:0] == KEY_DOWN);
        hit[H_LEFT]   = (code[7:0] == KEY_LEFT);
        hit[H_RIGHT]  = (code[7:0] == KEY_RIGHT);
        hit[H_SPACE]  = (code == KEY_SPACE);
        hit[H_CTRL]   = (code == KEY_CTRL);
        hit[H_START1] = (code == KEY_F1);
        hit[H_START2] = (code == KEY_F2);
        hit[H_COIN]   = (code == KEY_F3);
        return hit;
    endfunction

endpackage

// File: rtl/ps2_key_latch.sv
// PS/2 key event decoder: detects a toggle of ps2_key[10] and updates the
// held bit of the matching key with the pressed flag.
// Ports:
//   clk, rst      : clock, async active-high reset
//   ps2_key[10:0] : {toggle, pressed, code[8:0]} from hps_io
//   held[8:0]     : registered held-key vector (layout in ponpoko_input_pkg)
module ps2_key_latch
    import ponpoko_input_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [10:0]       ps2_key,
    output logic [HELD_W-1:0] held
);

    logic              old_tog;
    logic              key_event;
    logic [HELD_W-1:0] hit;

    always_comb begin
        key_event = (ps2_key[10] != old_tog);
        hit       = key_hit(ps2_key[8:0]);
    end

    // Only the bits selected by the decoded code take the pressed flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            old_tog <= 1'b0;
            held    <= '0;
        end else if (key_event) begin
            old_tog <= ps2_key[10];
            held    <= (held & ~hit) | (hit & {HELD_W{ps2_key[9]}});
        end
    end

endmodule

// File: rtl/ponpoko_input_seq.sv
// Input conditioning for the pacman core in0/in1 ports. Merges PS/2 held
// keys with the joystick word and replaces "coin = start" with a
// vblank-timed coin pulse, gap, start pulse sequence.
// Ports:
//   CLK, RESET     : system clock, async active-high reset
//   ps2_key[10:0]  : hps_io key word
//   joy[15:0]      : OR of both joysticks
//   vblank         : core vblank, synchronous to CLK
//   in0[7:0]       : {1, 1, ~coin, fire, down, right, left, up}
//   in1[7:0]       : {0, start2, start1, fire, down, right, left, up}
//   busy           : sequencer not idle
module ponpoko_input_seq
    import ponpoko_input_pkg::*;
#(
    parameter int unsigned COIN_FRAMES  = 4,
    parameter int unsigned GAP_FRAMES   = 8,
    parameter int unsigned START_FRAMES = 4,
    parameter int unsigned CNT_W        = 6
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joy,
    input  logic        vblank,
    output logic [7:0]  in0,
    output logic [7:0]  in1,
    output logic        busy
);

    localparam int unsigned CW1 = CNT_W + 1;

    logic [HELD_W-1:0] held;
    logic              up, down, left, right, fire, start1, start2, coin;
    logic              vb_d, tick;
    logic              st1_d, st2_d, start1_rise, start2_rise;
    seq_state_t        state, state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CW1-1:0]    cnt_inc;
    logic              sel, sel_next;
    logic              seq_coin, seq_start1, seq_start2;
    logic              unused_joy;

    ps2_key_latch u_key_latch (
        .clk     (CLK),
        .rst     (RESET),
        .ps2_key (ps2_key),
        .held    (held)
    );

    // Keyboard / joystick merge, tick and start edge detect
    always_comb begin
        up          = held[H_UP]     | joy[JOY_UP];
        down        = held[H_DOWN]   | joy[JOY_DOWN];
        left        = held[H_LEFT]   | joy[JOY_LEFT];
        right       = held[H_RIGHT]  | joy[JOY_RIGHT];
        fire        = held[H_SPACE]  | held[H_CTRL] | joy[JOY_FIRE];
        start1      = held[H_START1] | joy[JOY_START1];
        start2      = held[H_START2] | joy[JOY_START2];
        coin        = held[H_COIN]   | joy[JOY_COIN];
        tick        = vblank & ~vb_d;
        start1_rise = start1 & ~st1_d;
        start2_rise = start2 & ~st2_d;
        // Widened so a saturated counter cannot wrap in the compare.
        cnt_inc     = {1'b0, cnt} + CW1'(1);
        unused_joy  = ^joy[15:8];
    end

    // Sequencer next state and outputs; a phase ends on the tick that
    // brings the frame count up to its length (or the next tick for zero).
    always_comb begin
        state_next = state;
        sel_next   = sel;
        seq_coin   = 1'b0;
        seq_start1 = 1'b0;
        seq_start2 = 1'b0;
        unique case (state)
            SEQ_IDLE: begin
                if (start1_rise) begin
                    state_next = SEQ_COIN;
                    sel_next   = 1'b0;
                end else if (start2_rise) begin
                    state_next = SEQ_COIN;
                    sel_next   = 1'b1;
                end
            end
            SEQ_COIN: begin
                seq_coin = 1'b1;
                if (tick && (cnt_inc >= CW1'(COIN_FRAMES))) state_next = SEQ_GAP;
            end
            SEQ_GAP: begin
                if (tick && (cnt_inc >= CW1'(GAP_FRAMES))) state_next = SEQ_START;
            end
            SEQ_START: begin
                seq_start1 = ~sel;
                seq_start2 = sel;
                if (tick && (cnt_inc >= CW1'(START_FRAMES))) state_next = SEQ_HOLD;
            end
            SEQ_HOLD: begin
                if (!start1 && !start2) state_next = SEQ_IDLE;
            end
            default: state_next = SEQ_IDLE;
        endcase
    end

    // Sequencer state, frame counter and edge-detect history
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= SEQ_IDLE;
            cnt   <= '0;
            sel   <= 1'b0;
            vb_d  <= 1'b0;
            st1_d <= 1'b0;
            st2_d <= 1'b0;
        end else begin
            state <= state_next;
            sel   <= sel_next;
            vb_d  <= vblank;
            st1_d <= start1;
            st2_d <= start2;
            if (state_next != state) begin
                cnt <= '0;
            end else if (tick && (cnt != '1)) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Output registers; raw start buttons only feed the sequencer.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            in0  <= 8'hE0;
            in1  <= 8'h00;
            busy <= 1'b0;
        end else begin
            in0  <= {2'b11, ~(seq_coin | coin), fire, down, right, left, up};
            in1  <= {1'b0, seq_start2, seq_start1, fire, down, right, left, up};
            busy <= (state != SEQ_IDLE);
        end
    end

endmodule

// File: tb/tb_ponpoko_input_seq.sv
// Self-checking bench for ponpoko_input_seq: directed steps plus a random
// phase, every cycle compared against a behavioural model.
module tb_ponpoko_input_seq;

    localparam int COIN_F  = 4;
    localparam int GAP_F   = 8;
    localparam int START_F = 4;

    localparam int P_IDLE  = 0;
    localparam int P_COIN  = 1;
    localparam int P_GAP   = 2;
    localparam int P_START = 3;
    localparam int P_HOLD  = 4;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [10:0] ps2_key = '0;
    logic [15:0] joy = '0;
    logic        vblank = 1'b0;
    logic [7:0]  in0, in1;
    logic        busy;

    ponpoko_input_seq #(
        .COIN_FRAMES  (COIN_F),
        .GAP_FRAMES   (GAP_F),
        .START_FRAMES (START_F),
        .CNT_W        (6)
    ) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .ps2_key (ps2_key),
        .joy     (joy),
        .vblank  (vblank),
        .in0     (in0),
        .in1     (in1),
        .busy    (busy)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: keys held by name, sequencer as phase + frames left
    bit         held_m [string];
    bit         m_tog, m_vbd, m_s1d, m_s2d, m_sel;
    int         m_phase, m_left;
    logic [7:0] e0, e1;
    logic       eb;

    int coin_ticks, s1_ticks, s2_ticks;

    function automatic string key_name(input logic [8:0] code);
        case (code[7:0])
            8'h75: return "up";
            8'h72: return "down";
            8'h6B: return "left";
            8'h74: return "right";
            default: ;
        endcase
        case (code)
            9'h029: return "space";
            9'h014: return "ctrl";
            9'h005: return "f1";
            9'h006: return "f2";
            9'h004: return "f3";
            default: ;
        endcase
        return "";
    endfunction

    function automatic bit held_of(input string n);
        return held_m.exists(n) ? held_m[n] : 1'b0;
    endfunction

    function automatic int frames_of(input int p);
        case (p)
            P_COIN:  return COIN_F;
            P_GAP:   return GAP_F;
            P_START: return START_F;
            default: return 0;
        endcase
    endfunction

    task automatic enter(input int p);
        m_phase = p;
        m_left  = frames_of(p);
    endtask

    task automatic model_reset();
        held_m.delete();
        m_tog = 0; m_vbd = 0; m_s1d = 0; m_s2d = 0; m_sel = 0;
        m_phase = P_IDLE; m_left = 0;
        e0 = 8'hE0; e1 = 8'h00; eb = 1'b0;
    endtask

    task automatic model_step();
        bit up, dn, lf, rt, fi, s1, s2, cn, tick;
        string nm;
        up = held_of("up")    | joy[3];
        dn = held_of("down")  | joy[2];
        lf = held_of("left")  | joy[1];
        rt = held_of("right") | joy[0];
        fi = held_of("space") | held_of("ctrl") | joy[4];
        s1 = held_of("f1")    | joy[5];
        s2 = held_of("f2")    | joy[6];
        cn = held_of("f3")    | joy[7];
        tick = vblank && !m_vbd;
        e0 = {2'b11, !(cn || (m_phase == P_COIN)), fi, dn, rt, lf, up};
        e1 = {1'b0, (m_phase == P_START) && m_sel, (m_phase == P_START) && !m_sel,
              fi, dn, rt, lf, up};
        eb = (m_phase != P_IDLE);
        case (m_phase)
            P_IDLE: begin
                if (s1 && !m_s1d) begin
                    m_sel = 0; enter(P_COIN);
                end else if (s2 && !m_s2d) begin
                    m_sel = 1; enter(P_COIN);
                end
            end
            P_COIN, P_GAP, P_START: begin
                if (tick) begin
                    if (m_left <= 1) enter(m_phase + 1);
                    else m_left = m_left - 1;
                end
            end
            P_HOLD: if (!s1 && !s2) m_phase = P_IDLE;
            default: m_phase = P_IDLE;
        endcase
        m_s1d = s1; m_s2d = s2; m_vbd = vblank;
        if (ps2_key[10] != m_tog) begin
            m_tog = ps2_key[10];
            nm = key_name(ps2_key[8:0]);
            if (nm != "") held_m[nm] = ps2_key[9];
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: model advances on the edge, outputs compared 1 time unit later.
    task automatic step();
        @(posedge CLK);
        if (RESET) model_reset();
        else model_step();
        #1;
        check("in0", in0, e0);
        check("in1", in1, e1);
        check("busy", {7'b0, busy}, {7'b0, eb});
    endtask

    task automatic ps2_ev(input logic pressed, input logic [8:0] code);
        ps2_key = {~ps2_key[10], pressed, code};
        step();
    endtask

    // Four-cycle frame; tick-time samples of coin/start are tallied.
    task automatic frame();
        vblank = 1'b1;
        step();
        if (!in0[5]) coin_ticks++;
        if (in1[5])  s1_ticks++;
        if (in1[6])  s2_ticks++;
        vblank = 1'b0;
        repeat (3) step();
    endtask

    task automatic clear_tally();
        coin_ticks = 0; s1_ticks = 0; s2_ticks = 0;
    endtask

    initial begin
        model_reset();
        clear_tally();
        // Reset values
        step();
        step();
        check("rst_in0", in0, 8'hE0);
        check("rst_in1", in1, 8'h00);
        check("rst_busy", {7'b0, busy}, 8'h00);
        RESET = 1'b0;
        repeat (3) step();

        // PS/2 up key: two-cycle latency, E0 variant behaves the same
        ps2_ev(1'b1, 9'h075);
        check("up_lat1", {7'b0, in0[0]}, 8'h00);
        step();
        check("up_in0", {7'b0, in0[0]}, 8'h01);
        check("up_in1", {7'b0, in1[0]}, 8'h01);
        ps2_ev(1'b0, 9'h075);
        step();
        check("up_rel", {6'b0, in1[0], in0[0]}, 8'h00);
        ps2_ev(1'b1, 9'h175);
        step();
        check("e0up_in0", {7'b0, in0[0]}, 8'h01);
        ps2_ev(1'b0, 9'h175);
        repeat (2) step();

        // joy start1 pulse through a full sequence
        clear_tally();
        joy[5] = 1'b1;
        step();
        joy[5] = 1'b0;
        repeat (20) frame();
        check("seq_coin_ticks", 8'(coin_ticks), 8'd4);
        check("seq_s1_ticks", 8'(s1_ticks), 8'd4);
        check("seq_s2_ticks", 8'(s2_ticks), 8'd0);
        check("seq_busy_end", {7'b0, busy}, 8'h00);

        // Both starts rise together, then a stray start2 during GAP
        clear_tally();
        joy[5] = 1'b1; joy[6] = 1'b1;
        step();
        joy[5] = 1'b0; joy[6] = 1'b0;
        repeat (6) frame();
        joy[6] = 1'b1;
        step();
        joy[6] = 1'b0;
        repeat (14) frame();
        check("both_s1_ticks", 8'(s1_ticks), 8'd4);
        check("both_s2_ticks", 8'(s2_ticks), 8'd0);

        // F3 held during GAP forces coin without disturbing timing
        clear_tally();
        joy[5] = 1'b1;
        step();
        joy[5] = 1'b0;
        repeat (6) frame();
        ps2_ev(1'b1, 9'h004);
        step();
        check("f3_coin", {7'b0, in0[5]}, 8'h00);
        repeat (3) frame();
        ps2_ev(1'b0, 9'h004);
        repeat (11) frame();
        check("f3_s1_ticks", 8'(s1_ticks), 8'd4);

        // Unmapped code and a repeat without toggle flip
        ps2_ev(1'b1, 9'h01C);
        step();
        check("unmapped_in0", in0, 8'hE0);
        check("unmapped_in1", in1, 8'h00);
        ps2_key = {ps2_key[10], 1'b1, 9'h075};
        repeat (2) step();
        check("notoggle_in0", in0, 8'hE0);

        // Reset in the middle of COIN
        joy[5] = 1'b1;
        step();
        joy[5] = 1'b0;
        frame();
        ps2_key = '0;
        RESET = 1'b1;
        #1;
        model_reset();
        check("midrst_in0", in0, 8'hE0);
        check("midrst_in1", in1, 8'h00);
        check("midrst_busy", {7'b0, busy}, 8'h00);
        repeat (2) step();
        RESET = 1'b0;
        repeat (4) step();
        check("postrst_busy", {7'b0, busy}, 8'h00);

        // Random stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            joy      = 16'($urandom);
            joy[5]   = ($urandom_range(0, 59) == 0);
            joy[6]   = ($urandom_range(0, 59) == 0);
            joy[7]   = ($urandom_range(0, 29) == 0);
            vblank   = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 7) == 0) begin
                logic [8:0] codes [12];
                codes = '{9'h075, 9'h175, 9'h072, 9'h06B, 9'h174, 9'h029,
                          9'h014, 9'h005, 9'h006, 9'h004, 9'h01C, 9'h129};
                ps2_key = {~ps2_key[10], 1'($urandom), codes[$urandom_range(0, 11)]};
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
